// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Independent safety monitor on the lamp drives of the traffic controller.
// The six lamp drives go into one register stage. The checks run on that
// registered copy, so a fault flag rises two edges after the lamp change
// that caused it. The monitor checks:
//   1 conflict    : NS green/yellow lit while EW green/yellow lit
//   2 multi       : two or more lamps lit in one direction
//   3 dark        : a direction dark for more than MAX_DARK_CYC cycles
//   4 sequence    : a valid-state change other than G->Y, Y->R, R->G
//   5 short yellow: yellow left after fewer than MIN_YELLOW_CYC cycles
//   6 short green : green left after fewer than MIN_GREEN_CYC cycles
//                   (only when MONITOR_MIN_GREEN_EN is defined)
// The lowest code wins when several checks fire together. The first fault
// is latched with its code until it is cleared.
//
// Build option:
//   MONITOR_MIN_GREEN_EN - adds the green run counters and check 6.
//                          When undefined, code 6 is never produced.
//
// Ports:
//   clk         in   1  clock, rising edge
//   rst         in   1  asynchronous reset, active high
//   ns_red      in   1  NS red lamp drive
//   ns_yellow   in   1  NS yellow lamp drive
//   ns_green    in   1  NS green lamp drive
//   ew_red      in   1  EW red lamp drive
//   ew_yellow   in   1  EW yellow lamp drive
//   ew_green    in   1  EW green lamp drive
//   fault_clr   in   1  clear request for the latched fault (level)
//   fault       out  1  latched fault flag
//   fault_code  out  3  code of the latched fault, 0 = none
//   cycle_cnt   out  8  completed NS phases (NS Y->R), wraps at 255
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int unsigned MIN_YELLOW_CYC = 4,
    parameter int unsigned MAX_DARK_CYC   = 2,
    parameter int unsigned MIN_GREEN_CYC  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_red,
    input  logic       ns_yellow,
    input  logic       ns_green,
    input  logic       ew_red,
    input  logic       ew_yellow,
    input  logic       ew_green,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_cnt
);

    typedef enum logic [1:0] {
        LS_RED = 2'd0,
        LS_YEL = 2'd1,
        LS_GRN = 2'd2
    } lamp_state_t;

    typedef enum logic {
        ST_MONITOR = 1'b0,
        ST_FAULT   = 1'b1
    } mon_state_t;

    // Direction index: 0 = NS, 1 = EW. Lamp vector bits: [2]=R [1]=Y [0]=G.
    localparam int unsigned DIRS = 2;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: registered lamp drives
    // ------------------------------------------------------------------
    logic [2:0] r_lamp [DIRS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lamp[0] <= 3'b100;
            r_lamp[1] <= 3'b100;
        end else begin
            r_lamp[0] <= {ns_red, ns_yellow, ns_green};
            r_lamp[1] <= {ew_red, ew_yellow, ew_green};
        end
    end

    // ------------------------------------------------------------------
    // Per-direction tracking registers
    // ------------------------------------------------------------------
    lamp_state_t r_last [DIRS];   // last valid state, dark/multi cycles skipped
    logic [7:0]  r_ycnt [DIRS];   // consecutive yellow cycles
    logic [7:0]  r_dcnt [DIRS];   // consecutive dark cycles

    lamp_state_t w_cur      [DIRS];
    lamp_state_t w_last_nxt [DIRS];
    logic [7:0]  w_ycnt_nxt [DIRS];
    logic [7:0]  w_dcnt_nxt [DIRS];
    logic [DIRS-1:0] w_dark;
    logic [DIRS-1:0] w_multi;
    logic [DIRS-1:0] w_valid;
    logic [DIRS-1:0] w_chg;
    logic [DIRS-1:0] w_seq_bad;
    logic [DIRS-1:0] w_yel_short;
    logic [DIRS-1:0] w_dark_bad;
    logic            w_conflict;

`ifdef MONITOR_MIN_GREEN_EN
    logic [7:0]      r_gcnt     [DIRS];
    logic [7:0]      w_gcnt_nxt [DIRS];
    logic [DIRS-1:0] w_grn_short;
`endif

    always_comb begin
        for (int unsigned d = 0; d < DIRS; d++) begin
            w_cur[d]       = LS_RED;
            w_last_nxt[d]  = r_last[d];
            w_ycnt_nxt[d]  = r_ycnt[d];
            w_dcnt_nxt[d]  = r_dcnt[d];
            w_dark[d]      = 1'b0;
            w_multi[d]     = 1'b0;
            w_valid[d]     = 1'b0;
            w_chg[d]       = 1'b0;
            w_seq_bad[d]   = 1'b0;
            w_yel_short[d] = 1'b0;
            w_dark_bad[d]  = 1'b0;
`ifdef MONITOR_MIN_GREEN_EN
            w_gcnt_nxt[d]  = r_gcnt[d];
            w_grn_short[d] = 1'b0;
`endif

            w_dark[d]  = (r_lamp[d] == 3'b000);
            w_multi[d] = (r_lamp[d][2] & r_lamp[d][1]) |
                         (r_lamp[d][2] & r_lamp[d][0]) |
                         (r_lamp[d][1] & r_lamp[d][0]);
            w_valid[d] = !w_dark[d] && !w_multi[d];

            if (r_lamp[d][1]) begin
                w_cur[d] = LS_YEL;
            end else if (r_lamp[d][0]) begin
                w_cur[d] = LS_GRN;
            end else begin
                w_cur[d] = LS_RED;
            end

            // Comparison is against the last valid state so dark gaps
            // between two lamps are transparent to the sequence check.
            w_chg[d] = w_valid[d] && (w_cur[d] != r_last[d]);

            w_seq_bad[d] = w_chg[d] &&
                !(((r_last[d] == LS_GRN) && (w_cur[d] == LS_YEL)) ||
                  ((r_last[d] == LS_YEL) && (w_cur[d] == LS_RED)) ||
                  ((r_last[d] == LS_RED) && (w_cur[d] == LS_GRN)));

            w_yel_short[d] = w_chg[d] && (r_last[d] == LS_YEL) &&
                             (r_ycnt[d] < 8'(MIN_YELLOW_CYC));

            w_dark_bad[d] = w_dark[d] &&
                            ((9'(r_dcnt[d]) + 9'd1) > 9'(MAX_DARK_CYC));

`ifdef MONITOR_MIN_GREEN_EN
            w_grn_short[d] = w_chg[d] && (r_last[d] == LS_GRN) &&
                             (r_gcnt[d] < 8'(MIN_GREEN_CYC));
`endif

            if (w_valid[d]) begin
                w_last_nxt[d] = w_cur[d];
                w_dcnt_nxt[d] = '0;
                if (w_cur[d] == LS_YEL) begin
                    w_ycnt_nxt[d] = (r_last[d] == LS_YEL) ? sat_inc(r_ycnt[d]) : 8'd1;
                end
`ifdef MONITOR_MIN_GREEN_EN
                if (w_cur[d] == LS_GRN) begin
                    w_gcnt_nxt[d] = (r_last[d] == LS_GRN) ? sat_inc(r_gcnt[d]) : 8'd1;
                end
`endif
            end else if (w_dark[d]) begin
                w_dcnt_nxt[d] = sat_inc(r_dcnt[d]);
            end else begin
                w_dcnt_nxt[d] = '0;
            end
        end

        w_conflict = (|r_lamp[0][1:0]) & (|r_lamp[1][1:0]);
    end

    // Tracking keeps following the lamps in both FSM states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned d = 0; d < DIRS; d++) begin
                r_last[d] <= LS_RED;
                r_ycnt[d] <= '0;
                r_dcnt[d] <= '0;
`ifdef MONITOR_MIN_GREEN_EN
                r_gcnt[d] <= '0;
`endif
            end
        end else begin
            for (int unsigned d = 0; d < DIRS; d++) begin
                r_last[d] <= w_last_nxt[d];
                r_ycnt[d] <= w_ycnt_nxt[d];
                r_dcnt[d] <= w_dcnt_nxt[d];
`ifdef MONITOR_MIN_GREEN_EN
                r_gcnt[d] <= w_gcnt_nxt[d];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault priority encoder (lowest code wins)
    // ------------------------------------------------------------------
    logic [2:0] w_code;
    logic       w_any_fault;
    logic       w_ns_cycle;

    always_comb begin
        w_code = 3'd0;
        if (w_conflict) begin
            w_code = 3'd1;
        end else if (|w_multi) begin
            w_code = 3'd2;
        end else if (|w_dark_bad) begin
            w_code = 3'd3;
        end else if (|w_seq_bad) begin
            w_code = 3'd4;
        end else if (|w_yel_short) begin
            w_code = 3'd5;
`ifdef MONITOR_MIN_GREEN_EN
        end else if (|w_grn_short) begin
            w_code = 3'd6;
`endif
        end
        w_any_fault = (w_code != 3'd0);
        w_ns_cycle  = w_valid[0] && (r_last[0] == LS_YEL) && (w_cur[0] == LS_RED);
    end

    // ------------------------------------------------------------------
    // Monitor FSM
    // ------------------------------------------------------------------
    mon_state_t r_state;
    mon_state_t w_state_nxt;
    logic [2:0] r_code;
    logic [2:0] w_code_nxt;
    logic [7:0] r_cycle_cnt;
    logic [7:0] w_cycle_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_MONITOR;
            r_code      <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_cycle_cnt_nxt = r_cycle_cnt;
        case (r_state)
            ST_MONITOR: begin
                if (w_any_fault) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = w_code;
                end else if (w_ns_cycle) begin
                    w_cycle_cnt_nxt = r_cycle_cnt + 8'd1;
                end
            end
            ST_FAULT: begin
                // A clear attempt while a fault is still present replaces
                // the held code with the current one.
                if (fault_clr) begin
                    if (w_any_fault) begin
                        w_code_nxt = w_code;
                    end else begin
                        w_state_nxt = ST_MONITOR;
                        w_code_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_MONITOR;
                w_code_nxt  = '0;
            end
        endcase
    end

    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_code;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       fault_clr;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    traffic_conflict_monitor #(
        .MIN_YELLOW_CYC(4),
        .MAX_DARK_CYC  (2),
        .MIN_GREEN_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .fault_clr (fault_clr),
        .fault     (fault),
        .fault_code(fault_code),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic f_e, input logic [2:0] c_e,
                        input logic [7:0] n_e);
        chk({tag, ".fault"}, {7'd0, fault}, {7'd0, f_e});
        chk({tag, ".code"}, {5'd0, fault_code}, {5'd0, c_e});
        chk({tag, ".cnt"}, cycle_cnt, n_e);
    endtask

    // Drive lamps (R/Y/G vectors) and clear, then move 1 time unit past the edge.
    task automatic apply(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        {ns_red, ns_yellow, ns_green} = ns;
        {ew_red, ew_yellow, ew_green} = ew;
        fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {ns_red, ns_yellow, ns_green} = R;
        {ew_red, ew_yellow, ew_green} = R;
        fault_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ns_phase(input int ycyc);
        for (int i = 0; i < 8; i++) apply(G, R, 1'b0);
        for (int i = 0; i < ycyc; i++) apply(Y, R, 1'b0);
    endtask

    // One full legal cycle; fault must stay low at every step.
    task automatic legal_cycle(input logic [7:0] cnt_lo);
        for (int i = 0; i < 8; i++) begin apply(G, R, 1'b0); chk("legal.ng", {7'd0, fault}, 8'd0); end
        for (int i = 0; i < 4; i++) begin apply(Y, R, 1'b0); chk("legal.ny", {7'd0, fault}, 8'd0); end
        for (int i = 0; i < 8; i++) begin apply(R, G, 1'b0); chk("legal.eg", {7'd0, fault}, 8'd0); end
        for (int i = 0; i < 4; i++) begin apply(R, Y, 1'b0); chk("legal.ey", {7'd0, fault}, 8'd0); end
        chk("legal.cnt", cycle_cnt, cnt_lo + 8'd1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk3("reset", 1'b0, 3'd0, 8'd0);

        // Three legal cycles
        legal_cycle(8'd0);
        legal_cycle(8'd1);
        legal_cycle(8'd2);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("legal3", 1'b0, 3'd0, 8'd3);

        // Conflict: two-edge latency, then stays latched
        do_reset();
        apply(G, G, 1'b0);
        chk3("confl.k", 1'b0, 3'd0, 8'd0);
        apply(R, R, 1'b0);
        chk3("confl.k1", 1'b1, 3'd1, 8'd0);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("confl.held", 1'b1, 3'd1, 8'd0);

        // Short yellow (2 and 3 cycles) -> code 5
        do_reset();
        ns_phase(2);
        apply(R, R, 1'b0);
        chk3("yel2.pre", 1'b0, 3'd0, 8'd0);
        apply(R, R, 1'b0);
        chk3("yel2", 1'b1, 3'd5, 8'd0);
        do_reset();
        ns_phase(3);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("yel3", 1'b1, 3'd5, 8'd0);
        // Exactly the minimum -> no fault, phase counted
        do_reset();
        ns_phase(4);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("yel4", 1'b0, 3'd0, 8'd1);

        // Green directly to red -> code 4
        do_reset();
        ns_phase(0);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("g2r", 1'b1, 3'd4, 8'd0);

        // Dark: two tolerated, third -> code 3
        do_reset();
        apply(D, R, 1'b0);
        apply(D, R, 1'b0);
        apply(D, R, 1'b0);
        chk3("dark2", 1'b0, 3'd0, 8'd0);
        apply(R, R, 1'b0);
        chk3("dark3", 1'b1, 3'd3, 8'd0);

        // Two dark cycles between Y and R are transparent
        do_reset();
        ns_phase(4);
        apply(D, R, 1'b0);
        apply(D, R, 1'b0);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("ydr", 1'b0, 3'd0, 8'd1);

        // Conflict plus multi in one cycle -> code 1
        do_reset();
        apply(3'b011, G, 1'b0);
        apply(R, R, 1'b0);
        chk3("prio", 1'b1, 3'd1, 8'd0);
        // Multi alone -> code 2
        do_reset();
        apply(3'b101, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("multi", 1'b1, 3'd2, 8'd0);

        // Clear behaviour, frozen counter, resume, reset mid-fault
        do_reset();
        legal_cycle(8'd0);
        apply(R, R, 1'b0);
        apply(G, G, 1'b0);
        apply(G, G, 1'b0);
        chk3("clr.latch", 1'b1, 3'd1, 8'd1);
        apply(G, G, 1'b1);
        chk3("clr.confl1", 1'b1, 3'd1, 8'd1);
        apply(Y, R, 1'b1);
        chk3("clr.confl2", 1'b1, 3'd1, 8'd1);
        apply(Y, R, 1'b0);
        chk3("clr.ignore", 1'b1, 3'd1, 8'd1);
        apply(Y, R, 1'b0);
        apply(Y, R, 1'b0);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("clr.frozen", 1'b1, 3'd1, 8'd1);
        apply(R, R, 1'b1);
        chk3("clr.ok", 1'b0, 3'd0, 8'd1);
        ns_phase(4);
        apply(R, R, 1'b0);
        apply(R, R, 1'b0);
        chk3("clr.resume", 1'b0, 3'd0, 8'd2);
        apply(G, G, 1'b0);
        apply(G, G, 1'b0);
        chk3("rst.pre", 1'b1, 3'd1, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        chk3("rst.async", 1'b0, 3'd0, 8'd0);
        #2;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
